// File: rtl/alu_hs_pipe.sv
// rtl/alu_hs_pipe.sv - parametrised ALU with valid/ready handshake and iterative multiply
//
// Purpose: one-cycle ADD/SUB/AND/OR/XOR/NOT/SLA/SRA/SRL and a WIDTH-cycle
// shift-add MUL. Each result is held until the consumer accepts it.
// Optional feature macro: ALU_FLAGS_EN (adds the flags port and flag logic).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand bundle handshake (a, b, shamt, funct)
//   out_valid / out_ready result handshake (res, err[, flags])
//   funct                0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 NOT 6 SLA 7 SRA 8 SRL 9 MUL
//   err                  funct > 9
//   flags                {ovf, carry, neg, zero} (ALU_FLAGS_EN only)

module alu_hs_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic [5:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             err
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic [WIDTH-1:0] mul_sum;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (funct == 6'd9);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign err       = err_q;

  // Top bit of sub_full is the borrow, i.e. a < b unsigned.
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};

  // One shift-add step: the multiplicand walks left while the multiplier
  // walks right, so bit 0 of the multiplier always selects the partial product.
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (funct)
      6'd0:    alu_res = add_full[WIDTH-1:0];
      6'd1:    alu_res = sub_full[WIDTH-1:0];
      6'd2:    alu_res = a & b;
      6'd3:    alu_res = a | b;
      6'd4:    alu_res = a ^ b;
      6'd5:    alu_res = ~a;
      6'd6:    alu_res = a << shamt;
      6'd7:    alu_res = $unsigned($signed(a) >>> shamt);
      6'd8:    alu_res = a >> shamt;
      6'd9:    alu_res = '0;  // produced by the iterative path
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [3:0] flags_q, flags_d;
  logic [3:0] alu_flags;
  logic       alu_ovf;
  logic       alu_carry;

  assign flags = flags_q;

  always_comb begin
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    if (funct == 6'd0) begin
      alu_carry = add_full[WIDTH];
      alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
    end else if (funct == 6'd1) begin
      alu_carry = sub_full[WIDTH];
      alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
    end
    alu_flags = {alu_ovf, alu_carry, alu_res[WIDTH-1], (alu_res == '0)};
  end
`endif

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    err_d    = err_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`ifdef ALU_FLAGS_EN
    flags_d  = flags_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready && !in_valid) begin
          state_d = IDLE;
        end
        if (accept) begin
          if (is_mul) begin
            state_d  = BUSY;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d = DONE;
            res_d   = alu_res;
            err_d   = alu_err;
`ifdef ALU_FLAGS_EN
            flags_d = alu_flags;
`endif
          end
        end
      end
      BUSY: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = DONE;
          res_d   = mul_sum;
          err_d   = 1'b0;
`ifdef ALU_FLAGS_EN
          flags_d = {2'b00, mul_sum[WIDTH-1], (mul_sum == '0)};
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      res_q    <= '0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`ifdef ALU_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`ifdef ALU_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_hs_pipe.sv
// tb/tb_alu_hs_pipe.sv - self-checking bench for alu_hs_pipe (WIDTH=32)

module tb_alu_hs_pipe;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic [4:0]    shamt;
  logic [5:0]    funct;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  res;
  logic          err;
`ifdef ALU_FLAGS_EN
  logic [3:0]    flags;
`endif

  alu_hs_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .shamt(shamt), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .err(err)
`ifdef ALU_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [W-1:0] er;
    logic         ee;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every transferred result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(res), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_res", 64'(res), 64'(e.res));
        check("sb_err", 64'(err), 64'(e.err));
      end
    end
  end

  task automatic send(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [4:0] sh, input logic [W-1:0] er, input logic ee,
                      output int waits);
    exp_t e;
    bit   done;
    funct = f; a = av; b = bv; shamt = sh; in_valid = 1'b1;
    waits = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        e.res = er;
        e.err = ee;
        sb.push_back(e);
        done = 1;
      end else begin
        waits++;
        if (waits > 200) begin
          check("send_timeout", 64'(waits), 64'd0);
          done = 1;
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  function automatic vec_t mk(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic [4:0] sh, input logic [W-1:0] er, input logic ee);
    vec_t v;
    v.f = f; v.a = av; v.b = bv; v.sh = sh; v.er = er; v.ee = ee;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    int w;
    logic [W-1:0] ra, rb;

    tbl[0]  = mk(6'd0,  32'd5,          32'd7,          5'd0,  32'd12,         1'b0);
    tbl[1]  = mk(6'd1,  32'd3,          32'd5,          5'd0,  32'hFFFF_FFFE,  1'b0);
    tbl[2]  = mk(6'd2,  32'hF0F0_1234,  32'h0FF0_FFFF,  5'd0,  32'h00F0_1234,  1'b0);
    tbl[3]  = mk(6'd3,  32'hF000_0000,  32'h0000_000F,  5'd0,  32'hF000_000F,  1'b0);
    tbl[4]  = mk(6'd4,  32'hAAAA_5555,  32'hFFFF_0000,  5'd0,  32'h5555_5555,  1'b0);
    tbl[5]  = mk(6'd5,  32'h0000_FFFF,  32'd123,        5'd0,  32'hFFFF_0000,  1'b0);
    tbl[6]  = mk(6'd6,  32'h8000_0001,  32'd9,          5'd3,  32'h0000_0008,  1'b0);
    tbl[7]  = mk(6'd7,  32'h8000_0000,  32'd9,          5'd4,  32'hF800_0000,  1'b0);
    tbl[8]  = mk(6'd8,  32'h8000_0000,  32'd9,          5'd4,  32'h0800_0000,  1'b0);
    tbl[9]  = mk(6'd7,  32'h8000_0000,  32'd0,          5'd31, 32'hFFFF_FFFF,  1'b0);
    tbl[10] = mk(6'd7,  32'h4000_0000,  32'd0,          5'd31, 32'h0000_0000,  1'b0);
    tbl[11] = mk(6'd9,  32'h0001_0003,  32'h0000_0005,  5'd0,  32'h0005_000F,  1'b0);
    tbl[12] = mk(6'd9,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd0,  32'h0000_0001,  1'b0);
    tbl[13] = mk(6'd0,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'h0000_0000,  1'b0);
    tbl[14] = mk(6'd63, 32'h1234_5678,  32'd1,          5'd0,  32'h0000_0000,  1'b1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; shamt = '0; funct = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ALU_FLAGS_EN
    check("rst_flags", 64'(flags), 64'd0);
`endif
    @(posedge clk); #1;

    // ADD 5+7: result one cycle after accept, then drops.
    send(6'd0, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_res", 64'(res), 64'd12);
    check("add_err", 64'(err), 64'd0);
    @(negedge clk);
    check("add_drop", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Table of vectors, streamed through the scoreboard.
    for (int i = 0; i < 15; i++) begin
      send(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].er, tbl[i].ee, w);
    end
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // MUL latency: busy for exactly W edges, in_ready low throughout.
    send(6'd9, 32'h0001_0003, 32'h0000_0005, 5'd0, 32'h0005_000F, 1'b0, w);
    in_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      check("mul_busy_valid", 64'(out_valid), 64'd0);
      check("mul_busy_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    check("mul_done_valid", 64'(out_valid), 64'd1);
    check("mul_done_res", 64'(res), 64'h0005_000F);
    @(posedge clk); #1;

    // Backpressure: result held for 5 cycles, new inputs ignored.
    out_ready = 1'b0;
    send(6'd1, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 1'b0, w);
    funct = 6'd0; a = 32'd100; b = 32'd200; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_res", 64'(res), 64'hFFFF_FFFE);
      check("hold_in_ready", 64'(in_ready), 64'd0);
`ifdef ALU_FLAGS_EN
      check("hold_flags", 64'(flags), 64'b0110);
`endif
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Back-to-back ADD stream: one accept per cycle after the first.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      send(6'd0, ra, rb, 5'd0, ra + rb, 1'b0, w);
      if (i > 0) check("stream_wait", 64'(w), 64'd0);
    end
    send(6'd12, 32'h55, 32'h66, 5'd0, 32'd0, 1'b1, w);
    check("illegal_wait", 64'(w), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("illegal_res", 64'(res), 64'd0);
    check("illegal_err", 64'(err), 64'd1);
    @(posedge clk); #1;

    // Reset during MUL: pending result never appears.
    send(6'd9, 32'd7, 32'd9, 5'd0, 32'd63, 1'b0, w);
    in_valid = 1'b0;
    repeat (9) begin
      @(negedge clk);
      check("rstmul_busy", 64'(out_valid), 64'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rstmul_idle", 64'(in_ready), 64'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("rstmul_no_result", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(6'd0, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_add", 64'(res), 64'd2);

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
